demux_router: RTL and testbench
===============================

DEMUX_ROUTER -- requirements
Module: demux_router

Interface
REQ-001 The block SHALL have parameter NUM_BITS, default 4, giving the data word width.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-004 The block SHALL have port Entrada, input, NUM_BITS, the data word to route.
REQ-005 The block SHALL have port SEL, input, 2, the destination channel of Entrada (00->Saida0, 01->Saida1, 10->Saida2, 11->Saida3).
REQ-006 The block SHALL have port in_valid, input, 1, asserted when Entrada/SEL carry a word.
REQ-007 The block SHALL have port in_ready, output, 1, asserted when the block can accept a word this cycle.
REQ-008 The block SHALL have ports Saida0..Saida3, each output, NUM_BITS, the registered per-channel data.
REQ-009 The block SHALL have port out_valid, output, 4, where bit k flags that Saidak holds an undelivered word.
REQ-010 The block SHALL have port out_ready, input, 4, where bit k flags that the channel-k consumer accepts this cycle.
REQ-011 The block SHALL have ports Cnt0..Cnt3, each output, 8, per-channel delivery counters (present only per REQ-029).

Function
REQ-012 Each channel SHALL hold a one-entry register with a 2-state FSM: EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
REQ-013 in_ready SHALL be combinational: 1 when channel SEL is EMPTY or out_ready[SEL]=1, else 0.
REQ-014 An input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-015 On an input transfer, Saida[SEL] SHALL load Entrada and the channel SHALL enter or stay in FULL, giving a latency of exactly 1 cycle.
REQ-016 An output transfer on channel k SHALL occur on an edge where out_valid[k]=1 and out_ready[k]=1.
REQ-017 On an output transfer with no simultaneous input to k, channel k SHALL go EMPTY.
REQ-018 On a simultaneous output transfer and input transfer to channel k, the channel SHALL stay FULL with the new word, with no bubble and no loss.
REQ-019 While FULL and out_ready[k]=0, Saidak SHALL stay stable.
REQ-020 Channels SHALL be independent: a stalled channel SHALL NOT block inputs addressed to other channels.
REQ-021 When in_valid=0, SEL and Entrada SHALL NOT affect state.
REQ-022 Saidak SHALL retain its last value when EMPTY; consumers SHALL qualify it with out_valid[k].
REQ-023 At most one channel SHALL load per cycle; any number of channels SHALL drain per cycle.

Reset
REQ-024 Asserting rst_n=0 SHALL immediately force all channels to EMPTY, out_valid=0000, Saida0..3=0 and Cnt0..3=0, regardless of the clock.
REQ-025 A reset asserted mid-operation SHALL discard all held words, and no transfer SHALL be counted on that edge.
REQ-026 During reset, in_ready SHALL evaluate per REQ-013 with all channels EMPTY, i.e. 1; however, no transfer SHALL occur until rst_n=1.
REQ-027 The first transfer SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro DEMUX_ROUTER_COUNT_EN SHALL control the delivery counters.
REQ-029 With DEMUX_ROUTER_COUNT_EN defined, Cntk SHALL increment by 1 on each output transfer of channel k and wrap from 255 to 0.
REQ-030 Without DEMUX_ROUTER_COUNT_EN, ports Cnt0..Cnt3 and their registers SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Bench: reset, then out_ready=1111 and words 4'hA to SEL=00, 4'h5 to 01, 4'hC to 10, 4'h3 to 11 on consecutive cycles -> each appears on its Saida one cycle later with only that out_valid bit set.
REQ-032 Bench: out_ready[2]=0, send 4'h7 then 4'h9 to SEL=10 -> first accepted, in_ready=0 for second, Saida2=7 held stable; raise out_ready[2] -> 7 delivered, then 9 accepted with no cycle lost.
REQ-033 Bench: channel 1 FULL with out_ready[1]=1 and a new 4'hE to SEL=01 on the same edge -> out_valid[1] stays 1 and Saida1=E next cycle.
REQ-034 Bench: channel 0 stalled FULL, send 4'h2 to SEL=11 -> accepted and delivered on Saida3 unaffected.
REQ-035 Bench: with channels FULL, pulse rst_n low between clock edges -> out_valid=0000 and Saida=0 immediately; with DEMUX_ROUTER_COUNT_EN defined, 256 deliveries on channel 0 -> Cnt0 wraps to 0.

Source files
------------

// File: rtl/demux_router_if.sv
// Handshake and data bundle for demux_router: one input stream with a
// channel select, four registered output channels with per-channel handshake.
interface demux_router_if #(
  parameter int unsigned NUM_BITS = 4
);

  localparam int unsigned SEL_W  = 2;
  localparam int unsigned NUM_CH = 4;

  // Producer side
  logic [NUM_BITS-1:0] Entrada;
  logic [SEL_W-1:0]    SEL;
  logic                in_valid;
  logic                in_ready;

  // Consumer side
  logic [NUM_BITS-1:0] Saida0;
  logic [NUM_BITS-1:0] Saida1;
  logic [NUM_BITS-1:0] Saida2;
  logic [NUM_BITS-1:0] Saida3;
  logic [NUM_CH-1:0]   out_valid;
  logic [NUM_CH-1:0]   out_ready;

  // Environment view: drives words in, accepts words out
  modport master (
    output Entrada, SEL, in_valid, out_ready,
    input  in_ready, Saida0, Saida1, Saida2, Saida3, out_valid
  );

  // Router view
  modport slave (
    input  Entrada, SEL, in_valid, out_ready,
    output in_ready, Saida0, Saida1, Saida2, Saida3, out_valid
  );

endinterface

// File: rtl/demux_router.sv
// demux_router: routes one input word per cycle to one of four one-entry
// output channels selected by SEL. Each channel is an EMPTY/FULL register
// slice that can drain and refill on the same edge, so a continuously ready
// consumer sees full throughput. A stalled channel only back-pressures words
// addressed to it.
//
// Optional feature: define DEMUX_ROUTER_COUNT_EN to add the per-channel 8-bit
// delivery counters Cnt0..Cnt3 (wrap from 255 to 0). Without it the counter
// ports and registers do not exist.
module demux_router #(
  parameter int unsigned NUM_BITS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  demux_router_if.slave bus
`ifdef DEMUX_ROUTER_COUNT_EN
  ,
  output logic [7:0]   Cnt0,
  output logic [7:0]   Cnt1,
  output logic [7:0]   Cnt2,
  output logic [7:0]   Cnt3
`endif
);

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;
`ifdef DEMUX_ROUTER_COUNT_EN
  localparam int unsigned CNT_W  = 8;
`endif

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  logic [NUM_CH-1:0]   valid_c;
  logic                in_ready_c;
  logic [NUM_BITS-1:0] data_arr [NUM_CH];
`ifdef DEMUX_ROUTER_COUNT_EN
  logic [CNT_W-1:0]    cnt_arr  [NUM_CH];
`endif

  // Accept when the addressed channel is empty or is draining this edge
  assign in_ready_c = ~valid_c[bus.SEL] | bus.out_ready[bus.SEL];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch

    state_e              state_q;
    state_e              state_d;
    logic [NUM_BITS-1:0] data_q;
    logic [NUM_BITS-1:0] data_d;
    logic                ld_c;
    logic                drain_c;
    logic                full_c;

    // Input transfer to this channel and output transfer from it
    assign ld_c    = bus.in_valid & in_ready_c & (bus.SEL == SEL_W'(k));
    assign drain_c = full_c & bus.out_ready[k];

    // Channel state register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= EMPTY;
      end else begin
        state_q <= state_d;
      end
    end

    // Next state: a load wins over a drain, so drain+refill stays FULL
    always_comb begin
      state_d = state_q;
      unique case (state_q)
        EMPTY: begin
          if (ld_c) begin
            state_d = FULL;
          end
        end
        FULL: begin
          if (ld_c) begin
            state_d = FULL;
          end else if (drain_c) begin
            state_d = EMPTY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    // FSM output: channel holds an undelivered word
    always_comb begin
      full_c = 1'b0;
      if (state_q == FULL) begin
        full_c = 1'b1;
      end
    end

    // Data capture: only a load changes the word, so it stays stable while stalled
    always_comb begin
      data_d = data_q;
      if (ld_c) begin
        data_d = bus.Entrada;
      end
    end

    // Data register; keeps its value after draining
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q <= '0;
      end else begin
        data_q <= data_d;
      end
    end

    assign valid_c[k]  = full_c;
    assign data_arr[k] = data_q;

`ifdef DEMUX_ROUTER_COUNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Delivery count, wraps naturally at 2^CNT_W
    always_comb begin
      cnt_d = cnt_q;
      if (drain_c) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Delivery counter register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign cnt_arr[k] = cnt_q;
`endif

  end : g_ch

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = valid_c;
  assign bus.Saida0    = data_arr[0];
  assign bus.Saida1    = data_arr[1];
  assign bus.Saida2    = data_arr[2];
  assign bus.Saida3    = data_arr[3];

`ifdef DEMUX_ROUTER_COUNT_EN
  assign Cnt0 = cnt_arr[0];
  assign Cnt1 = cnt_arr[1];
  assign Cnt2 = cnt_arr[2];
  assign Cnt3 = cnt_arr[3];
`endif

endmodule

// File: tb/tb_demux_router.sv
// Directed bench for demux_router. The driver pushes every word it expects
// to be accepted onto a per-channel queue; an independent monitor pops and
// compares whenever a channel delivers (out_valid & out_ready before an edge).
module tb_demux_router;

  logic clk;
  logic rst_n;

  int tests;
  int fails;

  demux_router_if #(.NUM_BITS(4)) bus ();

`ifdef DEMUX_ROUTER_COUNT_EN
  logic [7:0] cnt0, cnt1, cnt2, cnt3;
`endif

  demux_router #(.NUM_BITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DEMUX_ROUTER_COUNT_EN
    ,
    .Cnt0  (cnt0),
    .Cnt1  (cnt1),
    .Cnt2  (cnt2),
    .Cnt3  (cnt3)
`endif
  );

  logic [3:0] saida [4];
  assign saida[0] = bus.Saida0;
  assign saida[1] = bus.Saida1;
  assign saida[2] = bus.Saida2;
  assign saida[3] = bus.Saida3;

  logic [3:0] exp_q [4][$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    for (int k = 0; k < 4; k++) exp_q[k].delete();
  endtask

  // Present one word for one edge; exp_rdy is the hand-computed in_ready
  task automatic send(input logic [3:0] d, input logic [1:0] s, input logic exp_rdy);
    bus.Entrada  = d;
    bus.SEL      = s;
    bus.in_valid = 1'b1;
    #1;
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    if (exp_rdy) exp_q[s].push_back(d);
    step();
    bus.in_valid = 1'b0;
  endtask

  // Monitor: a delivery happens on the next edge when valid & ready now
  always @(negedge clk) begin
    logic [3:0] e;
    for (int k = 0; k < 4; k++) begin
      if (rst_n && bus.out_valid[k] && bus.out_ready[k]) begin
        if (exp_q[k].size() == 0) begin
          tests++;
          fails++;
          $display("FAIL deliver_unexpected ch%0d: got %0h expected nothing", k, saida[k]);
        end else begin
          e = exp_q[k].pop_front();
          chk($sformatf("deliver_ch%0d", k), 32'(saida[k]), 32'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] words [4];
    words = '{4'hA, 4'h5, 4'hC, 4'h3};
    tests = 0;
    fails = 0;
    rst_n        = 1'b0;
    bus.Entrada  = '0;
    bus.SEL      = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 4'b0000;

    // Reset state
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    for (int k = 0; k < 4; k++) chk("rst_saida", 32'(saida[k]), 32'h0);
`ifdef DEMUX_ROUTER_COUNT_EN
    chk("rst_cnt0", 32'(cnt0), 32'h0);
    chk("rst_cnt3", 32'(cnt3), 32'h0);
`endif
    step();
    step();
    rst_n = 1'b1;

    // One word per channel, back to back, consumers always ready
    bus.out_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      send(words[i], 2'(i), 1'b1);
      chk("route_valid", 32'(bus.out_valid), 32'(1) << i);
      chk("route_data", 32'(saida[i]), 32'(words[i]));
    end
    step();
    chk("route_idle", 32'(bus.out_valid), 32'h0);

    // Stalled channel 2: second word waits, first held stable
    bus.out_ready = 4'b1011;
    send(4'h7, 2'd2, 1'b1);
    chk("stall_valid", 32'(bus.out_valid), 32'h4);
    chk("stall_data", 32'(bus.Saida2), 32'h7);
    bus.Entrada  = 4'h9;
    bus.SEL      = 2'd2;
    bus.in_valid = 1'b1;
    #1;
    chk("stall_in_ready", 32'(bus.in_ready), 32'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_hold", 32'(bus.Saida2), 32'h7);
      chk("stall_hold_valid", 32'(bus.out_valid), 32'h4);
      chk("stall_in_ready", 32'(bus.in_ready), 32'h0);
    end
    bus.out_ready = 4'b1111;
    #1;
    chk("release_in_ready", 32'(bus.in_ready), 32'h1);
    exp_q[2].push_back(4'h9);
    step();
    bus.in_valid = 1'b0;
    chk("release_valid", 32'(bus.out_valid), 32'h4);
    chk("release_data", 32'(bus.Saida2), 32'h9);
    step();
    chk("release_idle", 32'(bus.out_valid), 32'h0);

    // Same-edge drain and refill on channel 1
    send(4'hB, 2'd1, 1'b1);
    chk("refill_pre", 32'(bus.out_valid), 32'h2);
    send(4'hE, 2'd1, 1'b1);
    chk("refill_valid", 32'(bus.out_valid), 32'h2);
    chk("refill_data", 32'(bus.Saida1), 32'hE);
    step();
    chk("refill_idle", 32'(bus.out_valid), 32'h0);

    // Channel 0 stalled must not block channel 3
    bus.out_ready = 4'b1110;
    send(4'h6, 2'd0, 1'b1);
    send(4'h2, 2'd3, 1'b1);
    chk("indep_valid", 32'(bus.out_valid), 32'h9);
    chk("indep_data3", 32'(bus.Saida3), 32'h2);
    bus.Entrada = 4'hF;
    bus.SEL     = 2'd0;
    step();
    chk("indep_after", 32'(bus.out_valid), 32'h1);
    chk("no_valid_no_load", 32'(bus.Saida0), 32'h6);

    // Fill every channel, then an async reset pulse between edges
    bus.out_ready = 4'b0000;
    send(4'h1, 2'd1, 1'b1);
    send(4'h8, 2'd2, 1'b1);
    send(4'h4, 2'd3, 1'b1);
    chk("all_full", 32'(bus.out_valid), 32'hF);
    #1;
    rst_n = 1'b0;
    flush();
    #1;
    chk("async_rst_valid", 32'(bus.out_valid), 32'h0);
    chk("async_rst_in_ready", 32'(bus.in_ready), 32'h1);
    for (int k = 0; k < 4; k++) chk("async_rst_saida", 32'(saida[k]), 32'h0);
    #1;
    rst_n = 1'b1;

    // First edge after reset release accepts a word
    bus.out_ready = 4'b1111;
    send(4'hD, 2'd0, 1'b1);
    chk("post_rst_valid", 32'(bus.out_valid), 32'h1);
    chk("post_rst_data", 32'(bus.Saida0), 32'hD);
    step();
    chk("post_rst_idle", 32'(bus.out_valid), 32'h0);

`ifdef DEMUX_ROUTER_COUNT_EN
    chk("cnt0_one", 32'(cnt0), 32'h1);
    chk("cnt1_zero", 32'(cnt1), 32'h0);
    #1;
    rst_n = 1'b0;
    flush();
    #1;
    chk("cnt0_rst", 32'(cnt0), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) send(4'(i), 2'd0, 1'b1);
    chk("cnt0_255", 32'(cnt0), 32'hFF);
    step();
    chk("cnt0_wrap", 32'(cnt0), 32'h0);
    chk("cnt0_idle", 32'(bus.out_valid), 32'h0);
`endif

    step();
    for (int k = 0; k < 4; k++) chk("queue_drained", 32'(exp_q[k].size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
